// File: rtl/pl_io_port_bank.sv
// pl_io_port_bank: multi-channel I/O port unit for the pipelined core.
// Each input channel is synchronised, and every change of its value is logged
// into a small per-channel capture FIFO. The core reads a channel from that FIFO,
// or sees the live value when the FIFO is empty. Output channels are plain
// registers written by the core, and each write raises a one-cycle strobe.
module pl_io_port_bank #(
  parameter int DATA_W      = 8,
  parameter int N_CH        = 2,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = $clog2(N_CH + 1)
) (
  input  logic                   clk_f,
  input  logic                   rst_n,
  input  logic [ADDR_W-1:0]      io_addr,
  input  logic                   io_wr,
  input  logic                   io_rd,
  input  logic [DATA_W-1:0]      io_wdata,
  output logic [DATA_W-1:0]      io_rdata,
  output logic                   io_rvalid,
  output logic                   io_rempty,
  input  logic [N_CH*DATA_W-1:0] in_port,
  output logic [N_CH*DATA_W-1:0] out_port,
  output logic [N_CH-1:0]        out_strobe,
  output logic                   irq
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Stage 0 takes the pin and stage SYNC_STAGES-1 is the settled value.
  logic [SYNC_STAGES-1:0][DATA_W-1:0] sync_q [N_CH];
  logic [DATA_W-1:0]                  sync_s [N_CH];
  logic [DATA_W-1:0]                  last_q [N_CH];

  logic [DATA_W-1:0] mem_q    [N_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [N_CH];
  logic [PTR_W-1:0]  rd_ptr_q [N_CH];
  logic [CNT_W-1:0]  cnt_q    [N_CH];

  logic [N_CH-1:0] ovf_q, ovf_d;
  logic [N_CH-1:0] chg, full, pop, do_push, ovf_set, nonempty;
  logic            ovf_clr;

  logic [DATA_W-1:0]      rdata_q, rdata_d;
  logic                   rvalid_q;
  logic                   rempty_q, rempty_d;
  logic [N_CH*DATA_W-1:0] out_q;
  logic [N_CH-1:0]        strobe_q, strobe_d;
  logic                   irq_q;

  // Expose the settled synchroniser output of each channel.
  always_comb begin
    for (int c = 0; c < N_CH; c++) begin
      sync_s[c] = sync_q[c][SYNC_STAGES-1];
    end
  end

  // Read decode: choose the data source and decide whether the FIFO head is consumed.
  always_comb begin
    rdata_d  = '0;
    rempty_d = 1'b0;
    ovf_clr  = 1'b0;
    pop      = '0;
    if (io_rd) begin
      for (int c = 0; c < N_CH; c++) begin
        if (io_addr == ADDR_W'(c)) begin
          if (cnt_q[c] != '0) begin
            rdata_d = mem_q[c][rd_ptr_q[c]];
            pop[c]  = 1'b1;
          end else begin
            rdata_d  = sync_s[c];
            rempty_d = 1'b1;
          end
        end
      end
      if (io_addr == ADDR_W'(N_CH)) begin
        rdata_d = DATA_W'(ovf_q);
        ovf_clr = 1'b1;
      end
    end
  end

  // Capture decisions. When the FIFO is full, a push is accepted only if a pop
  // frees the head slot in the same cycle. A new overflow beats the clear that a
  // status read applies in that cycle.
  always_comb begin
    chg      = '0;
    full     = '0;
    do_push  = '0;
    ovf_set  = '0;
    nonempty = '0;
    for (int c = 0; c < N_CH; c++) begin
      chg[c]      = (sync_s[c] != last_q[c]);
      full[c]     = (cnt_q[c] == CNT_W'(FIFO_DEPTH));
      do_push[c]  = chg[c] & (~full[c] | pop[c]);
      ovf_set[c]  = chg[c] & full[c] & ~pop[c];
      nonempty[c] = (cnt_q[c] != '0);
    end
    ovf_d = (ovf_q & ~{N_CH{ovf_clr}}) | ovf_set;
  end

  // Write decode: an address outside the channel range produces no strobe.
  always_comb begin
    strobe_d = '0;
    for (int c = 0; c < N_CH; c++) begin
      strobe_d[c] = io_wr & (io_addr == ADDR_W'(c));
    end
  end

  // Synchronisers, change detection and the capture FIFOs.
  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c]   <= '0;
        last_q[c]   <= '0;
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
          mem_q[c][i] <= '0;
        end
      end
      ovf_q <= '0;
    end else begin
      for (int c = 0; c < N_CH; c++) begin
        sync_q[c] <= {sync_q[c][SYNC_STAGES-2:0], in_port[c*DATA_W +: DATA_W]};
        // The last value follows every change, even a dropped one, so a held value is logged only once.
        if (chg[c]) begin
          last_q[c] <= sync_s[c];
        end
        if (do_push[c]) begin
          mem_q[c][wr_ptr_q[c]] <= sync_s[c];
          wr_ptr_q[c]           <= wr_ptr_q[c] + PTR_W'(1);
        end
        if (pop[c]) begin
          rd_ptr_q[c] <= rd_ptr_q[c] + PTR_W'(1);
        end
        if (do_push[c] && !pop[c]) begin
          cnt_q[c] <= cnt_q[c] + CNT_W'(1);
        end else if (!do_push[c] && pop[c]) begin
          cnt_q[c] <= cnt_q[c] - CNT_W'(1);
        end
      end
      ovf_q <= ovf_d;
    end
  end

  // Registered bus responses, output pins, strobes and the interrupt.
  always_ff @(posedge clk_f or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      rempty_q <= 1'b0;
      out_q    <= '0;
      strobe_q <= '0;
      irq_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= io_rd;
      rempty_q <= rempty_d;
      strobe_q <= strobe_d;
      irq_q    <= |nonempty;
      for (int c = 0; c < N_CH; c++) begin
        if (strobe_d[c]) begin
          out_q[c*DATA_W +: DATA_W] <= io_wdata;
        end
      end
    end
  end

  assign io_rdata   = rdata_q;
  assign io_rvalid  = rvalid_q;
  assign io_rempty  = rempty_q;
  assign out_port   = out_q;
  assign out_strobe = strobe_q;
  assign irq        = irq_q;

endmodule
